feed_sequencer: RTL and testbench

- Sits directly upstream of a bank of NUM_ROWS data_feeder instances on the systolic array's input edge.
- Accepts one operand tile (one 8*BYTES_PER_WORD-bit word per array row) over a valid/ready handshake.
- Drives the feeders' data_in bus and a broadcast load pulse.
- Then issues per-row skewed enable strobes so row r starts shifting r cycles after row 0, giving the diagonal wavefront the systolic MAC array needs.

---
 rtl/feed_sequencer_if.sv | 28 ++
 rtl/feed_sequencer.sv | 141 ++++++++++++++
 tb/tb_feed_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/feed_sequencer_if.sv
// feed_sequencer_if: tile handshake plus feeder-side bus of the feed sequencer.
// master = tile producer / testbench side, slave = sequencer side.
interface feed_sequencer_if #(
  parameter int NUM_ROWS       = 4,
  parameter int BYTES_PER_WORD = 7
);
  localparam int W = 8 * BYTES_PER_WORD;

  logic [NUM_ROWS*W-1:0] tile_in;
  logic                  tile_valid;
  logic                  tile_ready;
  logic                  stall;
  logic [NUM_ROWS*W-1:0] feed_data;
  logic                  feed_load;
  logic [NUM_ROWS-1:0]   feed_enable;
  logic                  busy;
  logic                  done;

  modport master (
    output tile_in, tile_valid, stall,
    input  tile_ready, feed_data, feed_load, feed_enable, busy, done
  );

  modport slave (
    input  tile_in, tile_valid, stall,
    output tile_ready, feed_data, feed_load, feed_enable, busy, done
  );
endinterface

// File: rtl/feed_sequencer.sv
// feed_sequencer: accepts one operand tile, pulses feed_load to the row
// feeders, then issues per-row skewed shift enables (row r lags row 0 by r
// cycles) to form the diagonal wavefront of the systolic array.
// Optional build macro FEED_GAP_EN: inserts an idle gap cycle after every
// active FEED cycle for feeders whose PE needs one idle cycle per byte.

// Row enable window: row ROW shifts while ROW <= c < ROW + BPW.
module feed_seq_row #(
  parameter int ROW = 0,
  parameter int BPW = 7,
  parameter int CW  = 4
) (
  input  logic [CW-1:0] c_i,
  output logic          en_o
);
  assign en_o = (int'(c_i) >= ROW) && (int'(c_i) < ROW + BPW);
endmodule

module feed_sequencer #(
  parameter int NUM_ROWS       = 4,
  parameter int BYTES_PER_WORD = 7
) (
  input  logic clk,
  input  logic reset,
  feed_sequencer_if.slave bus
);
  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD + NUM_ROWS);
  // Last step index: row NUM_ROWS-1 sees its final byte here.
  localparam logic [CW-1:0] C_LAST = CW'(BYTES_PER_WORD + NUM_ROWS - 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DONE} state_t;

  state_t                state_q;
  logic [CW-1:0]         c_q, c_d;
  logic [NUM_ROWS-1:0]   mask_q, mask_d;
  logic [NUM_ROWS*W-1:0] data_q;
  logic                  load_q, busy_q, done_q, ready_q;
  logic                  active;
  logic                  adv;

`ifdef FEED_GAP_EN
  logic gap_q;
  // Gap cycles never drive enables and ignore stall.
  assign active = (state_q == S_FEED) && !gap_q;
`else
  assign active = (state_q == S_FEED);
`endif

  // A step is consumed only on an active, non-stalled FEED cycle.
  assign adv = active && !bus.stall;

  // Next step index: 0 when entering FEED from LOAD, else c+1.
  assign c_d = (state_q == S_FEED) ? c_q + CW'(1) : '0;

  // Enable mask for the next step is precomputed so that mask_q is a
  // register and only the same-cycle stall gate is combinational.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    feed_seq_row #(
      .ROW (r),
      .BPW (BYTES_PER_WORD),
      .CW  (CW)
    ) u_row (
      .c_i  (c_d),
      .en_o (mask_d[r])
    );
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef FEED_GAP_EN
      gap_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (bus.tile_valid && ready_q) begin
            data_q  <= bus.tile_in;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          load_q  <= 1'b0;
          c_q     <= '0;
          mask_q  <= mask_d;
          state_q <= S_FEED;
`ifdef FEED_GAP_EN
          gap_q   <= 1'b0;
`endif
        end
        S_FEED: begin
          if (adv) begin
            if (c_q == C_LAST) begin
              mask_q  <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              c_q    <= c_d;
              mask_q <= mask_d;
`ifdef FEED_GAP_EN
              gap_q  <= 1'b1;
`endif
            end
          end
`ifdef FEED_GAP_EN
          else if (gap_q) begin
            gap_q <= 1'b0;
          end
`endif
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.feed_enable = adv ? mask_q : '0;
  assign bus.feed_data   = data_q;
  assign bus.feed_load   = load_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.tile_ready  = ready_q;
endmodule

// File: tb/tb_feed_sequencer.sv
// tb_feed_sequencer: directed, table-driven bench for feed_sequencer.
// Cycle k below means the k-th cycle after the handshake edge (k=1 is LOAD).
`timescale 1ns/1ps
module tb_feed_sequencer;
  localparam int NR  = 4;
  localparam int BPW = 7;
  localparam int W   = 8 * BPW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  feed_sequencer_if #(.NUM_ROWS(NR), .BYTES_PER_WORD(BPW)) bus ();
  feed_sequencer #(.NUM_ROWS(NR), .BYTES_PER_WORD(BPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  feed_sequencer_if #(.NUM_ROWS(1), .BYTES_PER_WORD(BPW)) bus1 ();
  feed_sequencer #(.NUM_ROWS(1), .BYTES_PER_WORD(BPW)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic          stall;
    logic          valid;
    logic          load;
    logic [NR-1:0] en;
    logic          busy;
    logic          done;
    logic          ready;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int en_cnt [NR];

  logic [NR*W-1:0] tA, tB;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic v, input logic l,
                              input logic [NR-1:0] en, input logic b,
                              input logic d, input logic r);
    vec_t x;
    x.stall = s; x.valid = v; x.load = l; x.en = en;
    x.busy = b; x.done = d; x.ready = r;
    return x;
  endfunction

  // Entered at a posedge; leaves right after the handshake edge.
  task automatic handshake(input logic [NR*W-1:0] t);
    int n;
    n = 0;
    #2;
    while (bus.tile_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #2; n++;
    end
    chk("handshake_ready", 256'(bus.tile_ready), 256'(1'b1));
    bus.tile_in = t;
    bus.tile_valid = 1'b1;
    @(posedge clk);
  endtask

  // One table row: drive inputs for cycle k, sample, advance one clock.
  task automatic apply(input vec_t v, input int k, input logic [NR*W-1:0] t, input string nm);
    #1;
    bus.stall = v.stall;
    bus.tile_valid = v.valid;
    if (v.valid) bus.tile_in = ~t;
    #1;
    chk($sformatf("%s k%0d load", nm, k), 256'(bus.feed_load), 256'(v.load));
    chk($sformatf("%s k%0d en", nm, k), 256'(bus.feed_enable), 256'(v.en));
    chk($sformatf("%s k%0d busy", nm, k), 256'(bus.busy), 256'(v.busy));
    chk($sformatf("%s k%0d done", nm, k), 256'(bus.done), 256'(v.done));
    chk($sformatf("%s k%0d ready", nm, k), 256'(bus.tile_ready), 256'(v.ready));
    chk($sformatf("%s k%0d data", nm, k), 256'(bus.feed_data), 256'(t));
    for (int r = 0; r < NR; r++) if (bus.feed_enable[r]) en_cnt[r]++;
    @(posedge clk);
  endtask

  task automatic check_counts(input string nm);
    for (int r = 0; r < NR; r++)
      chk($sformatf("%s row%0d enable count", nm, r), 256'(en_cnt[r]), 256'(BPW));
  endtask

  task automatic clear_counts();
    for (int r = 0; r < NR; r++) en_cnt[r] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t base_v [13];
    vec_t stall_v [16];
    int nfeed;

    tA = {56'h0, 56'h0, 56'hA1B2C3D4E5F607, 56'h11223344556677};
    tB = {56'hDEADBEEF012345, 56'h0F0E0D0C0B0A09, 56'h55AA55AA55AA55, 56'h01020304050607};

    // stall, valid, load, en, busy, done, ready
    base_v[0]  = mk(0, 1, 1, 4'b0000, 1, 0, 0);
    base_v[1]  = mk(0, 0, 0, 4'b0001, 1, 0, 0);
    base_v[2]  = mk(0, 0, 0, 4'b0011, 1, 0, 0);
    base_v[3]  = mk(0, 0, 0, 4'b0111, 1, 0, 0);
    base_v[4]  = mk(0, 1, 0, 4'b1111, 1, 0, 0);
    base_v[5]  = mk(0, 0, 0, 4'b1111, 1, 0, 0);
    base_v[6]  = mk(0, 0, 0, 4'b1111, 1, 0, 0);
    base_v[7]  = mk(0, 0, 0, 4'b1111, 1, 0, 0);
    base_v[8]  = mk(0, 0, 0, 4'b1110, 1, 0, 0);
    base_v[9]  = mk(0, 0, 0, 4'b1100, 1, 0, 0);
    base_v[10] = mk(0, 0, 0, 4'b1000, 1, 0, 0);
    base_v[11] = mk(0, 1, 0, 4'b0000, 1, 1, 0);
    base_v[12] = mk(0, 0, 0, 4'b0000, 0, 0, 1);

    stall_v[0]  = mk(1, 0, 1, 4'b0000, 1, 0, 0);
    stall_v[1]  = mk(0, 0, 0, 4'b0001, 1, 0, 0);
    stall_v[2]  = mk(0, 0, 0, 4'b0011, 1, 0, 0);
    stall_v[3]  = mk(0, 0, 0, 4'b0111, 1, 0, 0);
    stall_v[4]  = mk(0, 0, 0, 4'b1111, 1, 0, 0);
    stall_v[5]  = mk(1, 0, 0, 4'b0000, 1, 0, 0);
    stall_v[6]  = mk(1, 0, 0, 4'b0000, 1, 0, 0);
    stall_v[7]  = mk(1, 0, 0, 4'b0000, 1, 0, 0);
    stall_v[8]  = mk(0, 0, 0, 4'b1111, 1, 0, 0);
    stall_v[9]  = mk(0, 0, 0, 4'b1111, 1, 0, 0);
    stall_v[10] = mk(0, 0, 0, 4'b1111, 1, 0, 0);
    stall_v[11] = mk(0, 0, 0, 4'b1110, 1, 0, 0);
    stall_v[12] = mk(0, 0, 0, 4'b1100, 1, 0, 0);
    stall_v[13] = mk(0, 0, 0, 4'b1000, 1, 0, 0);
    stall_v[14] = mk(1, 0, 0, 4'b0000, 1, 1, 0);
    stall_v[15] = mk(0, 0, 0, 4'b0000, 0, 0, 1);

    bus.tile_in = '0; bus.tile_valid = 1'b0; bus.stall = 1'b0;
    bus1.tile_in = '0; bus1.tile_valid = 1'b0; bus1.stall = 1'b0;

    // Reset state
    #2;
    chk("rst ready", 256'(bus.tile_ready), 256'(1'b0));
    chk("rst busy", 256'(bus.busy), 256'(1'b0));
    chk("rst load", 256'(bus.feed_load), 256'(1'b0));
    chk("rst en", 256'(bus.feed_enable), 256'(4'b0));
    chk("rst done", 256'(bus.done), 256'(1'b0));
    chk("rst data", 256'(bus.feed_data), 256'(0));
    #10;
    reset = 1'b0;
    chk("ready held low before first edge", 256'(bus.tile_ready), 256'(1'b0));
    @(posedge clk); #2;
    chk("ready after first edge", 256'(bus.tile_ready), 256'(1'b1));
    @(posedge clk);

`ifdef FEED_GAP_EN
    // Gap mode: active/gap alternation doubles FEED length.
    clear_counts();
    handshake(tA);
    for (int k = 1; k <= 22; k++) begin
      #1; bus.tile_valid = 1'b0; #1;
      chk($sformatf("gap k%0d en0", k), 256'(bus.feed_enable[0]),
          256'((k % 2 == 0) && k >= 2 && k <= 14));
      chk($sformatf("gap k%0d done", k), 256'(bus.done), 256'(k == 21));
      for (int r = 0; r < NR; r++) if (bus.feed_enable[r]) en_cnt[r]++;
      @(posedge clk);
    end
    check_counts("gap");
`else
    // Nominal tile with ignored tile_valid pulses in LOAD, FEED and DONE
    clear_counts();
    handshake(tA);
    for (int i = 0; i < 13; i++) apply(base_v[i], i + 1, tA, "base");
    check_counts("base");

    // Stall for three cycles at c=4; stall in LOAD/DONE has no effect
    clear_counts();
    handshake(tB);
    for (int i = 0; i < 16; i++) apply(stall_v[i], i + 1, tB, "stall");
    check_counts("stall");
    #1; bus.stall = 1'b0;

    // tile_valid held high: next handshake exactly 13 cycles later
    handshake(tA);
    for (int k = 1; k <= 14; k++) begin
      #1; bus.tile_in = tB; #1;
      chk($sformatf("b2b k%0d load", k), 256'(bus.feed_load), 256'(k == 1 || k == 14));
      chk($sformatf("b2b k%0d data", k), 256'(bus.feed_data), 256'((k < 14) ? tA : tB));
      @(posedge clk);
    end
    #1; bus.tile_valid = 1'b0;
    begin
      int n;
      n = 0;
      #1;
      while (bus.tile_ready !== 1'b1 && n < 40) begin @(posedge clk); #2; n++; end
      chk("b2b drain ready", 256'(bus.tile_ready), 256'(1'b1));
      @(posedge clk);
    end

    // Asynchronous reset mid-FEED at c=5
    handshake(tB);
    for (int k = 1; k <= 7; k++) begin
      #1; bus.tile_valid = 1'b0; #1;
      if (k < 7) @(posedge clk);
    end
    #1; reset = 1'b1; #1;
    chk("async rst en", 256'(bus.feed_enable), 256'(4'b0));
    chk("async rst busy", 256'(bus.busy), 256'(1'b0));
    chk("async rst load", 256'(bus.feed_load), 256'(1'b0));
    chk("async rst done", 256'(bus.done), 256'(1'b0));
    chk("async rst ready", 256'(bus.tile_ready), 256'(1'b0));
    chk("async rst data", 256'(bus.feed_data), 256'(0));
    #3; reset = 1'b0;
    @(posedge clk); #2;
    chk("ready after rst release", 256'(bus.tile_ready), 256'(1'b1));
    chk("busy after rst release", 256'(bus.busy), 256'(1'b0));
    @(posedge clk);
    nfeed = 0;
    handshake(tA);
    for (int k = 1; k <= 13; k++) begin
      #1; bus.tile_valid = 1'b0; #1;
      if (bus.feed_enable != '0) nfeed++;
      chk($sformatf("post-rst k%0d done", k), 256'(bus.done), 256'(k == 12));
      @(posedge clk);
    end
    chk("post-rst feed cycles", 256'(nfeed), 256'(10));

    // Single-row instance: skew collapses to 7 consecutive enables
    #2;
    chk("one-row ready", 256'(bus1.tile_ready), 256'(1'b1));
    bus1.tile_in = 56'h0123456789ABCD;
    bus1.tile_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      #1; bus1.tile_valid = 1'b0; #1;
      chk($sformatf("one-row k%0d en", k), 256'(bus1.feed_enable), 256'(k >= 2 && k <= 8));
      chk($sformatf("one-row k%0d done", k), 256'(bus1.done), 256'(k == 9));
      @(posedge clk);
    end
    chk("one-row data", 256'(bus1.feed_data), 256'(56'h0123456789ABCD));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
